// File: rtl/race_pkg.sv
// Shared race subsystem definitions.
// Used by the runner and the start/done controller.
package race_pkg;

  localparam int LAPW = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DONE = 3'd2,
    ST_COOL = 3'd3
  } state_t;

endpackage

// File: rtl/race_runner_if.sv
// Four-phase ready/start/done link between
// the race controller (master) and runner (slave).
interface race_runner_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic [CNT_W-1:0] lap_len;
  logic             ready;
  logic             done;
  logic             abort;

  modport master (
    output start,
    output lap_len,
    input  ready,
    input  done,
    input  abort
  );

  modport slave (
    input  start,
    input  lap_len,
    output ready,
    output done,
    output abort
  );

endinterface

// File: rtl/race_lap_timer.sv
// Loadable up-counter; last flags that the
// next increment reaches the loaded terminal.
module race_lap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] term_in,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      term  <= '0;
    end else if (load) begin
      count <= '0;
      term  <= term_in;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Extra bit keeps the compare exact at the max terminal.
  assign last =
    (({1'b0, count}) + (W+1)'(1)) == {1'b0, term};

endmodule

// File: rtl/race_runner.sv
// Race runner: accepts start, times a lap,
// holds done until start drops, then cools down.
module race_runner
  import race_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int COOLDOWN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  race_runner_if.slave      bus,
  output logic [CNT_W-1:0]  elapsed,
  output logic [LAPW-1:0]   lap_count
);

  localparam logic [CNT_W-1:0] COOL_T =
    CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_t state, state_d;

  logic ready_q, ready_d;
  logic done_q, done_d;
  logic abort_q, abort_d;
  logic accept;
  logic lap_ld, lap_inc, lap_last;
  logic cool_ld, cool_inc, cool_last;
  logic lap_hit;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] unused_cool_cnt;

  assign accept  = (state == ST_IDLE)
                 & ready_q & bus.start;
  assign len_eff = (bus.lap_len == '0)
                 ? ONE : bus.lap_len;

  race_lap_timer #(.W(CNT_W)) u_lap (
    .clk     (clk),
    .rst     (rst),
    .load    (lap_ld),
    .inc     (lap_inc),
    .term_in (len_eff),
    .count   (elapsed),
    .last    (lap_last)
  );

  race_lap_timer #(.W(CNT_W)) u_cool (
    .clk     (clk),
    .rst     (rst),
    .load    (cool_ld),
    .inc     (cool_inc),
    .term_in (COOL_T),
    .count   (unused_cool_cnt),
    .last    (cool_last)
  );

  always_comb begin
    state_d  = state;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    lap_ld   = 1'b0;
    lap_inc  = 1'b0;
    cool_ld  = 1'b0;
    cool_inc = 1'b0;
    lap_hit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_d = enable;
        if (accept) begin
          ready_d = 1'b0;
          lap_ld  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A dropped start wins over lap completion.
        if (!bus.start) begin
          abort_d = 1'b1;
          cool_ld = 1'b1;
          state_d = ST_COOL;
        end else begin
          lap_inc = 1'b1;
          if (lap_last) begin
            done_d  = 1'b1;
            lap_hit = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!bus.start) begin
          cool_ld = 1'b1;
          state_d = ST_COOL;
        end else begin
          done_d = 1'b1;
        end
      end
      ST_COOL: begin
        cool_inc = 1'b1;
        if (cool_last) begin
          ready_d = enable;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      lap_count <= '0;
    end else begin
      state   <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      if (lap_hit)
        lap_count <= lap_count + 1'b1;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.abort = abort_q;

endmodule

// File: tb/tb_race_runner.sv
// Directed bench for race_runner.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_race_runner;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] elapsed;
  logic [7:0]  lap_count;

  int pass_cnt = 0;
  int total    = 0;

  race_runner_if bus ();

  race_runner dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .elapsed   (elapsed),
    .lap_count (lap_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic run_lap(
    input  logic [15:0] len,
    output bit          ok
  );
    bit r;
    int n;
    ok = 1'b1;
    wait_ready(r);
    if (!r) ok = 1'b0;
    bus.lap_len = len;
    bus.start   = 1'b1;
    step();
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (bus.done !== 1'b1) ok = 1'b0;
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst         = 1'b0;
    enable      = 1'b1;
    bus.start   = 1'b0;
    bus.lap_len = 16'd0;
    #3;
    total++;
    if (bus.ready !== 1'b0 || bus.done !== 1'b0
        || lap_count !== 8'd0 || elapsed !== 16'd0)
      $display("FAIL reset_vals: rdy=%b done=%b lc=%0d el=%0d want 0",
               bus.ready, bus.done, lap_count, elapsed);
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", bus.ready);
    else pass_cnt++;
    total++;
    if (bus.done !== 1'b0 || lap_count !== 8'd0)
      $display("FAIL reset_done_lc: done=%b lc=%0d want 0/0",
               bus.done, lap_count);
    else pass_cnt++;
  endtask

  task automatic test_lap5;
    bus.lap_len = 16'd5;
    bus.start   = 1'b1;
    step();
    total++;
    if (bus.ready !== 1'b0 || elapsed !== 16'd0)
      $display("FAIL lap5_accept: rdy=%b el=%0d want 0/0",
               bus.ready, elapsed);
    else pass_cnt++;
    repeat (4) step();
    total++;
    if (bus.done !== 1'b0 || elapsed !== 16'd4)
      $display("FAIL lap5_early: done=%b el=%0d want 0/4",
               bus.done, elapsed);
    else pass_cnt++;
    step();
    total++;
    if (bus.done !== 1'b1 || elapsed !== 16'd5
        || lap_count !== 8'd1)
      $display("FAIL lap5_done: done=%b el=%0d lc=%0d want 1/5/1",
               bus.done, elapsed, lap_count);
    else pass_cnt++;
    step();
    total++;
    if (bus.done !== 1'b1 || elapsed !== 16'd5)
      $display("FAIL lap5_hold: done=%b el=%0d want 1/5",
               bus.done, elapsed);
    else pass_cnt++;
    bus.start = 1'b0;
    step();
    total++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b0)
      $display("FAIL lap5_drop: done=%b rdy=%b want 0/0",
               bus.done, bus.ready);
    else pass_cnt++;
    step();
    total++;
    if (bus.ready !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL lap5_cool: rdy=%b done=%b want 0/0",
               bus.ready, bus.done);
    else pass_cnt++;
    step();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL lap5_reready: got %b want 1", bus.ready);
    else pass_cnt++;
  endtask

  task automatic test_zero_len;
    bit ok;
    bus.lap_len = 16'd0;
    bus.start   = 1'b1;
    step();
    step();
    total++;
    if (bus.done !== 1'b1 || elapsed !== 16'd1
        || lap_count !== 8'd2)
      $display("FAIL zero_len: done=%b el=%0d lc=%0d want 1/1/2",
               bus.done, elapsed, lap_count);
    else pass_cnt++;
    bus.start = 1'b0;
    step();
    wait_ready(ok);
    total++;
    if (!ok)
      $display("FAIL zero_len_ready: timeout got %b want 1",
               bus.ready);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    bus.lap_len = 16'd10;
    bus.start   = 1'b1;
    step();
    step();
    step();
    total++;
    if (elapsed !== 16'd2)
      $display("FAIL abort_pre: el=%0d want 2", elapsed);
    else pass_cnt++;
    bus.start = 1'b0;
    step();
    total++;
    if (bus.abort !== 1'b1 || bus.done !== 1'b0
        || elapsed !== 16'd2)
      $display("FAIL abort_pulse: ab=%b done=%b el=%0d want 1/0/2",
               bus.abort, bus.done, elapsed);
    else pass_cnt++;
    step();
    total++;
    if (bus.abort !== 1'b0 || bus.ready !== 1'b0
        || elapsed !== 16'd2 || lap_count !== 8'd2)
      $display("FAIL abort_after: ab=%b rdy=%b el=%0d lc=%0d want 0/0/2/2",
               bus.abort, bus.ready, elapsed, lap_count);
    else pass_cnt++;
    step();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL abort_reready: got %b want 1", bus.ready);
    else pass_cnt++;
  endtask

  task automatic test_enable_and_reset;
    enable = 1'b0;
    step();
    total++;
    if (bus.ready !== 1'b0)
      $display("FAIL en_low_ready: got %b want 0", bus.ready);
    else pass_cnt++;
    bus.start = 1'b1;
    step();
    step();
    total++;
    if (bus.ready !== 1'b0 || bus.done !== 1'b0
        || elapsed !== 16'd2)
      $display("FAIL en_low_noacc: rdy=%b done=%b el=%0d want 0/0/2",
               bus.ready, bus.done, elapsed);
    else pass_cnt++;
    bus.start = 1'b0;
    enable    = 1'b1;
    step();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL en_high_ready: got %b want 1", bus.ready);
    else pass_cnt++;
    // enable falls on the same edge start is accepted
    enable      = 1'b0;
    bus.start   = 1'b1;
    bus.lap_len = 16'd10;
    step();
    total++;
    if (bus.ready !== 1'b0 || elapsed !== 16'd0)
      $display("FAIL en_drop_acc: rdy=%b el=%0d want 0/0",
               bus.ready, elapsed);
    else pass_cnt++;
    step();
    step();
    total++;
    if (elapsed !== 16'd2)
      $display("FAIL en_drop_run: el=%0d want 2", elapsed);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.ready !== 1'b0 || bus.done !== 1'b0
        || bus.abort !== 1'b0 || elapsed !== 16'd0
        || lap_count !== 8'd0)
      $display("FAIL async_rst: rdy=%b done=%b ab=%b el=%0d lc=%0d want 0",
               bus.ready, bus.done, bus.abort, elapsed, lap_count);
    else pass_cnt++;
    bus.start = 1'b0;
    enable    = 1'b1;
    #2;
    rst = 1'b1;
    step();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL rst_rel_ready: got %b want 1", bus.ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    for (int lap = 0; lap < 3; lap++) begin
      wait_ready(ok);
      total++;
      if (!ok)
        $display("FAIL b2b_ready: lap %0d timeout got %b want 1",
                 lap, bus.ready);
      else pass_cnt++;
      bus.lap_len = 16'd3;
      bus.start   = 1'b1;
      step();
      n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      total++;
      if (n !== 3 || elapsed !== 16'd3)
        $display("FAIL b2b_done: lap %0d edges=%0d el=%0d want 3/3",
                 lap, n, elapsed);
      else pass_cnt++;
      bus.start = 1'b0;
      step();
      total++;
      if (bus.ready !== 1'b0 || bus.done !== 1'b0)
        $display("FAIL b2b_waitlow: lap %0d rdy=%b done=%b want 0/0",
                 lap, bus.ready, bus.done);
      else pass_cnt++;
    end
    total++;
    if (lap_count !== 8'd3)
      $display("FAIL b2b_count: got %0d want 3", lap_count);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    bit ok;
    int bad = 0;
    for (int i = 0; i < 252; i++) begin
      run_lap(16'd1, ok);
      if (!ok) bad++;
    end
    total++;
    if (bad !== 0 || lap_count !== 8'd255)
      $display("FAIL wrap_255: lc=%0d stalls=%0d want 255/0",
               lap_count, bad);
    else pass_cnt++;
    run_lap(16'd1, ok);
    total++;
    if (!ok || lap_count !== 8'd0)
      $display("FAIL wrap_0: lc=%0d ok=%b want 0/1",
               lap_count, ok);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lap5();
    test_zero_len();
    test_abort();
    test_enable_and_reset();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
